// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared types and constants for the snake game engine.
//   dir_t     - heading / key direction (2-bit code as seen on user_direction)
//   NO_KEY    - user_direction code meaning "no key pressed" (bit2 set)
//   pos_t     - one grid cell (x, y)
//   state_t   - engine state (PLAY, OVER)
//   INIT_*    - starting body, food, length and heading of a fresh game
// Coordinates are COORD_W bits wide, enough for grids up to 8x8 cells.
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int COORD_W = 3;
    localparam int SIZE_W  = 4;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    localparam logic [2:0] NO_KEY = 3'b100;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam pos_t              INIT_BODY0 = '{x: 3'd4, y: 3'd4};
    localparam pos_t              INIT_BODY1 = '{x: 3'd3, y: 3'd4};
    localparam pos_t              INIT_BODY2 = '{x: 3'd2, y: 3'd4};
    localparam pos_t              INIT_FOOD  = '{x: 3'd1, y: 3'd1};
    localparam logic [SIZE_W-1:0] INIT_SIZE  = 4'd3;
    localparam dir_t              INIT_DIR   = RIGHT;

    // The encoding pairs opposite directions so that flipping bit0 reverses.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    // Body cell contents of a freshly started game; unused slots are zero.
    function automatic pos_t init_cell(input int idx);
        case (idx)
            0:       return INIT_BODY0;
            1:       return INIT_BODY1;
            2:       return INIT_BODY2;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/snake_if.sv
// -----------------------------------------------------------------------------
// snake_if
// Game-level signals between the snake engine and the rest of the game.
//   user_direction   3  key code from the player (3'b1xx = no key)
//   reset            1  synchronous game restart, active high
//   random_direction 2  free-running pseudo-random direction
//   size             4  current snake length
//   done             1  game over (collision or maximum length)
// master: the game top / controller side; slave: snake_core.
// -----------------------------------------------------------------------------
interface snake_if;
    import snake_pkg::*;

    logic [2:0]        user_direction;
    logic              reset;
    logic [1:0]        random_direction;
    logic [SIZE_W-1:0] size;
    logic              done;

    modport master (
        output user_direction,
        output reset,
        input  random_direction,
        input  size,
        input  done
    );

    modport slave (
        input  user_direction,
        input  reset,
        output random_direction,
        output size,
        output done
    );

endinterface

// File: rtl/snake_lfsr.sv
// -----------------------------------------------------------------------------
// snake_lfsr
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left with the
// feedback entering bit0. Steps on every clock; restart_i reloads the seed.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous reset, active low (loads SEED)
//   restart_i  synchronous reload of SEED
//   bits_o     low six state bits: [1:0] direction, [5:3]/[2:0] food x/y
// -----------------------------------------------------------------------------
module snake_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       restart_i,
    output logic [5:0] bits_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (restart_i) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bits_o = lfsr_q[5:0];

endmodule

// File: rtl/snake_core.sv
// -----------------------------------------------------------------------------
// snake_core
// Snake game engine: holds the body and food on a GRID_W x GRID_H grid,
// moves the head one cell every MOVE_TICKS clocks in the player's direction,
// grows on food, and flags game over on collision or on reaching MAX_LEN.
// Ports:
//   i_clk  clock (all logic on posedge)
//   i_rst  asynchronous reset, active low
//   bus    snake_if.slave: user_direction, reset (sync restart),
//          random_direction, size, done
// -----------------------------------------------------------------------------
module snake_core
    import snake_pkg::*;
#(
    parameter int         GRID_W     = 8,
    parameter int         GRID_H     = 8,
    parameter int         MAX_LEN    = 15,
    parameter int         MOVE_TICKS = 4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic    i_clk,
    input  logic    i_rst,
    snake_if.slave  bus
);

    localparam int                 TICK_W    = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(MOVE_TICKS - 1);
    localparam int                 CW1       = COORD_W + 1;
    localparam logic [CW1-1:0]     GRID_W_C  = CW1'(GRID_W);
    localparam logic [CW1-1:0]     GRID_H_C  = CW1'(GRID_H);
    localparam logic [SIZE_W-1:0]  MAX_LEN_C = SIZE_W'(MAX_LEN);

    state_t            state_q, state_d;
    dir_t              heading_q, heading_d;
    dir_t              pending_q, pending_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    pos_t              body_q [MAX_LEN];
    pos_t              body_d [MAX_LEN];
    logic [SIZE_W-1:0] size_q, size_d;
    pos_t              food_q, food_d;
    logic              food_valid_q, food_valid_d;
    logic              done_q, done_d;

    logic [5:0]        rnd;
    logic              key_valid;
    dir_t              key_dir;
    dir_t              move_dir;
    logic              step;
    logic [CW1-1:0]    next_x, next_y;
    pos_t              next_head;
    logic              off_grid, eat, hit, moving;
    pos_t              food_cand;
    logic              cand_taken;

    snake_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i     (i_clk),
        .rst_ni    (i_rst),
        .restart_i (bus.reset),
        .bits_o    (rnd)
    );

    // Step geometry and collision tests. The step uses the freshest legal
    // key (this cycle's key if valid, else the pending one), so a key held
    // into the step cycle still steers that step.
    always_comb begin
        key_dir   = dir_t'(bus.user_direction[1:0]);
        key_valid = (state_q == PLAY) && !bus.user_direction[2] &&
                    (key_dir != reverse_dir(heading_q));
        move_dir  = key_valid ? key_dir : pending_q;
        step      = (state_q == PLAY) && (tick_q == TICK_LAST);

        next_x = {1'b0, body_q[0].x};
        next_y = {1'b0, body_q[0].y};
        case (move_dir)
            UP:      next_y = {1'b0, body_q[0].y} - CW1'(1);
            DOWN:    next_y = {1'b0, body_q[0].y} + CW1'(1);
            LEFT:    next_x = {1'b0, body_q[0].x} - CW1'(1);
            default: next_x = {1'b0, body_q[0].x} + CW1'(1);
        endcase

        // Underflow wraps to a large value, so one compare covers both edges.
        off_grid  = (next_x >= GRID_W_C) || (next_y >= GRID_H_C);
        next_head = '{x: next_x[COORD_W-1:0], y: next_y[COORD_W-1:0]};
        eat       = food_valid_q && !off_grid && (next_head == food_q);

        // The tail cell moves away this step unless the snake is growing.
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(size_q)) && (body_q[i] == next_head) &&
                (eat || (i != int'(size_q) - 1))) begin
                hit = 1'b1;
            end
        end
        moving = step && !off_grid && !hit;

        // Food candidate is checked against the body as it will be after
        // this cycle, including a head arriving and a tail leaving.
        food_cand  = '{x: COORD_W'(int'(rnd[5:3]) % GRID_W),
                       y: COORD_W'(int'(rnd[2:0]) % GRID_H)};
        cand_taken = moving && (food_cand == next_head);
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(size_q)) && (body_q[i] == food_cand) &&
                !(moving && !eat && (i == int'(size_q) - 1))) begin
                cand_taken = 1'b1;
            end
        end
    end

    // Next-state logic for the whole engine. A game restart wins over
    // everything; in OVER all game state holds while the LFSR keeps running.
    always_comb begin
        state_d      = state_q;
        heading_d    = heading_q;
        pending_d    = pending_q;
        tick_d       = tick_q;
        body_d       = body_q;
        size_d       = size_q;
        food_d       = food_q;
        food_valid_d = food_valid_q;
        done_d       = done_q;

        if (bus.reset) begin
            state_d      = PLAY;
            heading_d    = INIT_DIR;
            pending_d    = INIT_DIR;
            tick_d       = '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_d[i] = init_cell(i);
            end
            size_d       = INIT_SIZE;
            food_d       = INIT_FOOD;
            food_valid_d = 1'b1;
            done_d       = 1'b0;
        end else if (state_q == PLAY) begin
            if (key_valid) begin
                pending_d = key_dir;
            end
            tick_d = step ? '0 : tick_q + TICK_W'(1);

            if (step) begin
                heading_d = move_dir;
                pending_d = move_dir;
                if (off_grid || hit) begin
                    state_d = OVER;
                    done_d  = 1'b1;
                end else begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        body_d[i] = body_q[i-1];
                    end
                    body_d[0] = next_head;
                    if (eat) begin
                        size_d = size_q + SIZE_W'(1);
                        if ((size_q + SIZE_W'(1)) == MAX_LEN_C) begin
                            state_d = OVER;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            // Place new food after eating, retrying each cycle until free.
            if ((moving && eat) || !food_valid_q) begin
                if (cand_taken) begin
                    food_valid_d = 1'b0;
                end else begin
                    food_d       = food_cand;
                    food_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= PLAY;
            heading_q    <= INIT_DIR;
            pending_q    <= INIT_DIR;
            tick_q       <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_q[i] <= init_cell(i);
            end
            size_q       <= INIT_SIZE;
            food_q       <= INIT_FOOD;
            food_valid_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            heading_q    <= heading_d;
            pending_q    <= pending_d;
            tick_q       <= tick_d;
            body_q       <= body_d;
            size_q       <= size_d;
            food_q       <= food_d;
            food_valid_q <= food_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.random_direction = rnd[1:0];
    assign bus.size             = size_q;
    assign bus.done             = done_q;

endmodule

// File: tb/tb_snake_core.sv
// -----------------------------------------------------------------------------
// tb_snake_core
// Directed bench for snake_core (MOVE_TICKS = 4). Each step drives the key
// and restart inputs, queues the expected size/done, runs some clocks and
// then pops the expectation and compares it with the engine outputs. The
// random direction is compared against an independent LFSR model.
// -----------------------------------------------------------------------------
module tb_snake_core;
    import snake_pkg::*;

    typedef struct {
        string      tag;
        logic [3:0] size;
        logic       done;
    } expect_t;

    logic       clk;
    logic       rstN;
    int         checks   = 0;
    int         failures = 0;
    expect_t    sbQ[$];
    logic [7:0] lfsrModel;
    logic [1:0] firstRand;
    logic       randChanged;

    snake_if bus ();

    snake_core #(
        .GRID_W     (8),
        .GRID_H     (8),
        .MAX_LEN    (15),
        .MOVE_TICKS (4),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .i_clk (clk),
        .i_rst (rstN),
        .bus   (bus)
    );

    // Free-running 100 MHz-style clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit0.
    function automatic logic [7:0] lfsrNext(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Advances n clocks, tracking the LFSR model, and ends on a falling edge
    // so outputs are sampled away from the active edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (bus.reset) lfsrModel = 8'hA5;
            else           lfsrModel = lfsrNext(lfsrModel);
            @(negedge clk);
        end
    endtask

    // One counted comparison with an immediate assertion.
    task automatic compare(input string tag, input logic [7:0] observed,
                           input logic [7:0] required);
        checks++;
        assert (observed === required) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, required);
        end
    endtask

    // Pops the oldest expectation and checks size, done and random_direction.
    task automatic checkOutput();
        expect_t e;
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sbQ.pop_front();
        compare({e.tag, ".size"}, 8'(bus.size), 8'(e.size));
        compare({e.tag, ".done"}, 8'(bus.done), 8'(e.done));
        compare({e.tag, ".rand"}, 8'(bus.random_direction), 8'(lfsrModel[1:0]));
    endtask

    // Drives one directed step, queues what it should produce, runs it and checks.
    task automatic applyStimulus(input logic [2:0] dir, input logic rst,
                                 input int cycles, input string tag,
                                 input logic [3:0] expSize, input logic expDone);
        expect_t e;
        bus.user_direction = dir;
        bus.reset          = rst;
        e.tag  = tag;
        e.size = expSize;
        e.done = expDone;
        sbQ.push_back(e);
        tick(cycles);
        checkOutput();
    endtask

    // Directed sequence: reset, wall hit, ignored reverse key, eating food,
    // synchronous and asynchronous restarts, then a long frozen game-over run.
    initial begin
        rstN               = 1'b0;
        bus.user_direction = NO_KEY;
        bus.reset          = 1'b0;
        lfsrModel          = 8'hA5;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        applyStimulus(NO_KEY, 1'b0, 0, "reset", 4'd3, 1'b0);

        applyStimulus(NO_KEY, 1'b0, 15, "right15", 4'd3, 1'b0);
        applyStimulus(NO_KEY, 1'b0, 1,  "right16", 4'd3, 1'b1);

        applyStimulus(3'b010, 1'b1, 1,  "restartA",  4'd3, 1'b0);
        applyStimulus(3'b010, 1'b0, 15, "reverse15", 4'd3, 1'b0);
        applyStimulus(3'b010, 1'b0, 1,  "reverse16", 4'd3, 1'b1);

        applyStimulus(3'b000, 1'b1, 1,  "restartB",   4'd3, 1'b0);
        applyStimulus(3'b000, 1'b0, 12, "upSteps",    4'd3, 1'b0);
        applyStimulus(3'b010, 1'b0, 11, "leftBefore", 4'd3, 1'b0);
        applyStimulus(3'b010, 1'b0, 1,  "eatFood",    4'd4, 1'b0);

        applyStimulus(3'b010, 1'b1, 1,  "midRestart", 4'd3, 1'b0);
        applyStimulus(NO_KEY, 1'b0, 15, "resume15",   4'd3, 1'b0);
        applyStimulus(NO_KEY, 1'b0, 1,  "resume16",   4'd3, 1'b1);

        begin
            expect_t e;
            #1 rstN = 1'b0;
            lfsrModel = 8'hA5;
            e.tag  = "asyncReset";
            e.size = 4'd3;
            e.done = 1'b0;
            sbQ.push_back(e);
            #2;
            checkOutput();
            rstN = 1'b1;
        end
        applyStimulus(NO_KEY, 1'b0, 15, "asyncResume15", 4'd3, 1'b0);
        applyStimulus(NO_KEY, 1'b0, 1,  "asyncResume16", 4'd3, 1'b1);

        firstRand   = bus.random_direction;
        randChanged = 1'b0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(3'($urandom_range(0, 7)), 1'b0, 100,
                          $sformatf("frozen%0d", k), 4'd3, 1'b1);
            if (bus.random_direction !== firstRand) randChanged = 1'b1;
        end
        compare("randomChanges", 8'(randChanged), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
